// File: rtl/mem_access_stage.sv
// Data-memory access stage: doubleword load/store with fixed wait latency.
// Define MISALIGN_TRAP_EN to flag and suppress misaligned accesses via fault.
module mem_access_stage #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reqValid,
  input  logic [63:0] address,
  input  logic [63:0] writeData,
  input  logic        controlMemRead,
  input  logic        controlMemWrite,
  output logic        stall,
  output logic        respValid,
  output logic [63:0] dataMemRead,
  output logic [63:0] dataAddress
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        fault
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          is_wr_q, is_wr_d;
  logic          resp_q, resp_d;
  logic [63:0]   rdata_q, rdata_d;
  logic [63:0]   daddr_q, daddr_d;

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] idx;
  logic          has_op;
  logic          accept_mem;
  logic          commit;
  logic          mis;
  logic          mem_we;

  assign idx        = addr_q[3 +: AW];
  assign has_op     = controlMemRead | controlMemWrite;
  assign accept_mem = (state_q == S_IDLE) & reqValid & has_op;
  assign commit     = (state_q == S_WAIT) & (cnt_q == '0);

`ifdef MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  assign mis   = |addr_q[2:0];
  assign fault = fault_q;
`else
  assign mis = 1'b0;
`endif

  // A misaligned store never reaches the array
  assign mem_we = commit & is_wr_q & ~mis;

  assign stall       = (state_q == S_WAIT) | accept_mem;
  assign respValid   = resp_q;
  assign dataMemRead = rdata_q;
  assign dataAddress = daddr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    rdata_d = rdata_q;
    daddr_d = daddr_q;
    resp_d  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    fault_d = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (reqValid) begin
          if (has_op) begin
            addr_d  = address;
            wdata_d = writeData;
            is_wr_d = controlMemWrite;
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end else begin
            daddr_d = address;
            rdata_d = '0;
            resp_d  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          resp_d  = 1'b1;
          daddr_d = addr_q;
          rdata_d = (is_wr_q | mis) ? '0 : mem_q[idx];
`ifdef MISALIGN_TRAP_EN
          fault_d = mis;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      daddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      daddr_q <= daddr_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`endif

  // Array is not reset; a reset edge cancels an uncommitted store
  always_ff @(posedge clk) begin
    if (reset_n && mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed table, corner sequences,
// and randomized traffic checked against a doubleword-array model.
module tb_mem_access_stage;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        reqValid;
  logic [63:0] address;
  logic [63:0] writeData;
  logic        controlMemRead;
  logic        controlMemWrite;
  logic        stall;
  logic        respValid;
  logic [63:0] dataMemRead;
  logic [63:0] dataAddress;
`ifdef MISALIGN_TRAP_EN
  logic        fault;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] mem_m [DEPTH];

  typedef struct {
    logic        r;
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [8];

  mem_access_stage #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .reqValid        (reqValid),
    .address         (address),
    .writeData       (writeData),
    .controlMemRead  (controlMemRead),
    .controlMemWrite (controlMemWrite),
    .stall           (stall),
    .respValid       (respValid),
    .dataMemRead     (dataMemRead),
    .dataAddress     (dataAddress)
`ifdef MISALIGN_TRAP_EN
    ,
    .fault           (fault)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit misal(input logic r, input logic w,
                               input logic [63:0] a);
`ifdef MISALIGN_TRAP_EN
    return (r | w) && (a[2:0] != 3'b0);
`else
    return 1'b0;
`endif
  endfunction

  // Whole-transaction model: returns the load data the response must carry
  function automatic logic [63:0] model_step(input logic r, input logic w,
                                             input logic [63:0] a,
                                             input logic [63:0] d);
    int idx;
    idx = int'((a >> 3) % DEPTH);
    if (!(r | w)) return 64'd0;
    if (misal(r, w, a)) return 64'd0;
    if (w) begin
      mem_m[idx] = d;
      return 64'd0;
    end
    return mem_m[idx];
  endfunction

  task automatic clr_inputs();
    reqValid        = 1'b0;
    controlMemRead  = 1'b0;
    controlMemWrite = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    clr_inputs();
    #1;
    chk("idle_resp", 64'(respValid), 64'd0);
    chk("idle_stall", 64'(stall), 64'd0);
  endtask

  task automatic xact(input logic r, input logic w, input logic [63:0] a,
                      input logic [63:0] d, input logic [63:0] exp_rd);
    bit   mem;
    bit   got;
    int   exp_lat;
    logic prev_stall;
    mem        = r | w;
    exp_lat    = mem ? LAT + 1 : 1;
    got        = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    reqValid        = 1'b1;
    controlMemRead  = r;
    controlMemWrite = w;
    address         = a;
    writeData       = d;
    #1;
    for (int c = 0; c <= exp_lat + 3 && !got; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (!prev_stall) clr_inputs();
        #1;
      end
      chk("stall", 64'(stall), 64'(mem && c <= LAT));
      prev_stall = stall;
      if (respValid) begin
        got = 1'b1;
        chk("resp_cycle", 64'(c), 64'(exp_lat));
        chk("dataMemRead", dataMemRead, exp_rd);
        chk("dataAddress", dataAddress, a);
`ifdef MISALIGN_TRAP_EN
        chk("fault", 64'(fault), 64'(misal(r, w, a)));
`endif
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL resp_timeout: got no respValid expected cycle %0d",
               exp_lat);
    end
    clr_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] e;
    logic [63:0] b2b [3];
    int op;

    for (int i = 0; i < DEPTH; i++) mem_m[i] = 64'd0;

    tbl[0] = '{1'b0, 1'b1, 64'h18,   64'hDEADBEEF_CAFEF00D, 64'h0};
    tbl[1] = '{1'b1, 1'b0, 64'h18,   64'h0, 64'hDEADBEEF_CAFEF00D};
    tbl[2] = '{1'b0, 1'b1, 64'h208,  64'h01234567_89ABCDEF, 64'h0};
    tbl[3] = '{1'b1, 1'b0, 64'h8,    64'h0, 64'h01234567_89ABCDEF};
    tbl[4] = '{1'b1, 1'b1, 64'h10,   64'h5555AAAA_12345678, 64'h0};
    tbl[5] = '{1'b1, 1'b0, 64'h10,   64'h0, 64'h5555AAAA_12345678};
    tbl[6] = '{1'b1, 1'b0, 64'h20,   64'h0, 64'h0};
    tbl[7] = '{1'b0, 1'b0, 64'h1234, 64'h0, 64'h0};

    // Reset held two cycles with a store pending at the input
    reset_n         = 1'b0;
    reqValid        = 1'b1;
    controlMemRead  = 1'b0;
    controlMemWrite = 1'b1;
    address         = 64'h40;
    writeData       = 64'h99;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_resp", 64'(respValid), 64'd0);
    chk("rst_rdata", dataMemRead, 64'd0);
    chk("rst_addr", dataAddress, 64'd0);
`ifdef MISALIGN_TRAP_EN
    chk("rst_fault", 64'(fault), 64'd0);
`endif
    reset_n = 1'b1;
    clr_inputs();
    #1;
    chk("rst_stall", 64'(stall), 64'd0);

    for (int i = 0; i < 8; i++) begin
      void'(model_step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d));
      xact(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp);
    end

    // Back-to-back non-memory requests, one response per cycle
    b2b[0] = 64'h1234;
    b2b[1] = 64'h1238;
    b2b[2] = 64'h123C;
    @(negedge clk);
    reqValid  = 1'b1;
    address   = b2b[0];
    #1;
    chk("b2b_stall0", 64'(stall), 64'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c < 3) address = b2b[c];
      else reqValid = 1'b0;
      #1;
      chk("b2b_resp", 64'(respValid), 64'd1);
      chk("b2b_addr", dataAddress, b2b[c-1]);
      chk("b2b_rdata", dataMemRead, 64'd0);
      chk("b2b_stall", 64'(stall), 64'd0);
    end
    @(negedge clk);
    #1;
    chk("b2b_end", 64'(respValid), 64'd0);

    // Reset in cycle 1 of a store: the store must never land
    @(negedge clk);
    reqValid        = 1'b1;
    controlMemWrite = 1'b1;
    address         = 64'h40;
    writeData       = 64'd5;
    #1;
    chk("mid_stall", 64'(stall), 64'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    clr_inputs();
    #1;
    chk("mid_resp", 64'(respValid), 64'd0);
    chk("mid_stall2", 64'(stall), 64'd0);
    repeat (3) idle_cycle();
    e = model_step(1'b1, 1'b0, 64'h40, 64'h0);
    xact(1'b1, 1'b0, 64'h40, 64'h0, e);
    chk("mid_model", e, 64'd0);

`ifdef MISALIGN_TRAP_EN
    void'(model_step(1'b0, 1'b1, 64'h40, 64'h77));
    xact(1'b0, 1'b1, 64'h40, 64'h77, 64'h0);
    void'(model_step(1'b0, 1'b1, 64'h43, 64'h88));
    xact(1'b0, 1'b1, 64'h43, 64'h88, 64'h0);
    void'(model_step(1'b1, 1'b0, 64'h40, 64'h0));
    xact(1'b1, 1'b0, 64'h40, 64'h0, 64'h77);
`endif

    for (int i = 0; i < 250; i++) begin
      op = int'($urandom_range(0, 4));
      a  = {$urandom(), $urandom()};
      d  = {$urandom(), $urandom()};
      a[8:3] = 6'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'b0;
      case (op)
        0: idle_cycle();
        1: begin
          e = model_step(1'b0, 1'b0, a, d);
          xact(1'b0, 1'b0, a, d, e);
        end
        2: begin
          e = model_step(1'b1, 1'b0, a, d);
          xact(1'b1, 1'b0, a, d, e);
        end
        3: begin
          e = model_step(1'b0, 1'b1, a, d);
          xact(1'b0, 1'b1, a, d, e);
        end
        default: begin
          e = model_step(1'b1, 1'b1, a, d);
          xact(1'b1, 1'b1, a, d, e);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
